byte_mem_ctrl: RTL and testbench

Parametrised byte-addressed, big-endian data/instruction memory for the multicycle MIPS datapath.
Supports byte, halfword and word loads and stores, with optional sign extension on loads.
Uses a req/ready handshake with configurable read and write latency so the control FSM can stall on memory.
Flags misaligned, out-of-range and reserved-size accesses instead of corrupting state.

---
 rtl/byte_mem_ctrl_pkg.sv | 25 ++
 rtl/byte_mem_ctrl_if.sv | 28 ++
 rtl/byte_mem_ctrl_load_align.sv | 33 +++
 rtl/byte_mem_ctrl.sv | 156 +++++++++++++++
 tb/tb_byte_mem_ctrl.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/byte_mem_ctrl_pkg.sv
// Shared definitions for the byte-addressed memory controller.
//   - access size encodings carried on the size bus
//   - FSM state constants for the controller
//   - size_bytes(): number of bytes touched by an access size (0 for reserved)
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      SZ_WORD: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/byte_mem_ctrl_if.sv
// Request/response bus between the control FSM (master) and the memory
// controller (slave).
//   req/we/size/sign_ext/address/write_data : request, master -> slave
//   read_data/ready/busy/err                : response, slave -> master
interface byte_mem_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              sign_ext;
  logic [ADDR_W-1:0] address;
  logic [31:0]       write_data;
  logic [31:0]       read_data;
  logic              ready;
  logic              busy;
  logic              err;

  modport master (
    output req, we, size, sign_ext, address, write_data,
    input  read_data, ready, busy, err
  );

  modport slave (
    input  req, we, size, sign_ext, address, write_data,
    output read_data, ready, busy, err
  );
endinterface

// File: rtl/byte_mem_ctrl_load_align.sv
// Combinational load formatter: turns the four raw bytes at a..a+3
// (b0_i = mem[a], most significant in big-endian order) into the
// right-justified, optionally sign-extended 32-bit load result.
//   b0_i..b3_i : raw bytes
//   size_i     : access size
//   sign_ext_i : replicate the top bit of the loaded byte/half
//   data_o     : formatted result (0 for reserved size)
module mem_load_align
  import mem_pkg::*;
(
  input  logic [7:0]  b0_i,
  input  logic [7:0]  b1_i,
  input  logic [7:0]  b2_i,
  input  logic [7:0]  b3_i,
  input  logic [1:0]  size_i,
  input  logic        sign_ext_i,
  output logic [31:0] data_o
);

  logic ext_bit;
  assign ext_bit = sign_ext_i & b0_i[7];

  always_comb begin
    data_o = '0;
    case (size_i)
      SZ_BYTE: data_o = {{24{ext_bit}}, b0_i};
      SZ_HALF: data_o = {{16{ext_bit}}, b0_i, b1_i};
      SZ_WORD: data_o = {b0_i, b1_i, b2_i, b3_i};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/byte_mem_ctrl.sv
// Big-endian byte-addressed memory with a req/ready handshake and fixed
// read/write latencies. Misaligned, out-of-range and reserved-size
// accesses complete with err=1 and leave the array untouched.
//   clk   : clock
//   rst_n : asynchronous active-low reset (array contents are not reset)
//   bus   : slave side of byte_mem_ctrl_if
module byte_mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  byte_mem_ctrl_if.slave  bus
);

  localparam int AW1     = ADDR_W + 1;
  localparam int IDX_W   = $clog2(DEPTH);
  localparam int LAT_MAX = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);
  localparam logic [AW1-1:0] DEPTH_L = AW1'(DEPTH);

  logic [7:0] mem_q [DEPTH];

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rd_q, rd_d;
  logic              err_q, err_d;

  logic              we_q, sx_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wd_q;

  logic [AW1-1:0]    baddr [4];
  logic [7:0]        rbyte [4];
  logic [2:0]        nbytes;
  logic [AW1-1:0]    end_addr;
  logic              acc_err;
  logic              mem_we;
  logic [31:0]       load_val;

  // Byte addresses a..a+3 at one extra bit so the range check cannot wrap;
  // bytes beyond the array read as zero.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      baddr[k] = {1'b0, addr_q} + AW1'(k);
      rbyte[k] = (baddr[k] < DEPTH_L) ? mem_q[baddr[k][IDX_W-1:0]] : 8'h00;
    end
  end

  assign nbytes   = size_bytes(size_q);
  assign end_addr = {1'b0, addr_q} + AW1'(nbytes) - AW1'(1);
  assign acc_err  = (size_q == SZ_RSVD)
                  | ((size_q == SZ_HALF) & addr_q[0])
                  | ((size_q == SZ_WORD) & (addr_q[1:0] != 2'b00))
                  | (end_addr >= DEPTH_L);

  mem_load_align u_align (
    .b0_i       (rbyte[0]),
    .b1_i       (rbyte[1]),
    .b2_i       (rbyte[2]),
    .b3_i       (rbyte[3]),
    .size_i     (size_q),
    .sign_ext_i (sx_q),
    .data_o     (load_val)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          state_d = ST_ACCESS;
          cnt_d   = bus.we ? CNT_W'(WRITE_LAT) : CNT_W'(READ_LAT);
        end
      end
      ST_ACCESS: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_RESP;
          err_d   = acc_err;
          mem_we  = we_q & ~acc_err;
          if (!we_q) rd_d = acc_err ? 32'h0 : load_val;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        err_d   = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

  // Request capture: only meaningful while an access is in flight.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && bus.req) begin
      we_q   <= bus.we;
      size_q <= bus.size;
      sx_q   <= bus.sign_ext;
      addr_q <= bus.address;
      wd_q   <= bus.write_data;
    end
  end

  // Store: write_data is right-justified, mem[a] receives the most
  // significant of the stored bytes.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      case (size_q)
        SZ_BYTE: mem_q[baddr[0][IDX_W-1:0]] <= wd_q[7:0];
        SZ_HALF: begin
          mem_q[baddr[0][IDX_W-1:0]] <= wd_q[15:8];
          mem_q[baddr[1][IDX_W-1:0]] <= wd_q[7:0];
        end
        SZ_WORD: begin
          mem_q[baddr[0][IDX_W-1:0]] <= wd_q[31:24];
          mem_q[baddr[1][IDX_W-1:0]] <= wd_q[23:16];
          mem_q[baddr[2][IDX_W-1:0]] <= wd_q[15:8];
          mem_q[baddr[3][IDX_W-1:0]] <= wd_q[7:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.read_data = rd_q;
  assign bus.ready     = (state_q == ST_RESP);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.err       = err_q;

endmodule

// File: tb/tb_byte_mem_ctrl.sv
module tb_byte_mem_ctrl;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst_a_n = 1'b0;
  logic rst_b_n = 1'b0;
  always #5 clk = ~clk;

  byte_mem_ctrl_if #(.ADDR_W(8)) bus_a ();
  byte_mem_ctrl_if #(.ADDR_W(8)) bus_b ();

  // A: reduced depth so aligned out-of-range accesses exist.
  byte_mem_ctrl #(.ADDR_W(8), .DEPTH(128), .READ_LAT(2), .WRITE_LAT(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_a_n),
    .bus   (bus_a)
  );

  byte_mem_ctrl #(.ADDR_W(8), .DEPTH(256), .READ_LAT(2), .WRITE_LAT(3)) dut_b (
    .clk   (clk),
    .rst_n (rst_b_n),
    .bus   (bus_b)
  );

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        sx;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic drive(input bit sel, input logic r, input logic w, input logic [1:0] s,
                       input logic sx, input logic [7:0] a, input logic [31:0] d);
    if (!sel) begin
      bus_a.req = r; bus_a.we = w; bus_a.size = s; bus_a.sign_ext = sx;
      bus_a.address = a; bus_a.write_data = d;
    end else begin
      bus_b.req = r; bus_b.we = w; bus_b.size = s; bus_b.sign_ext = sx;
      bus_b.address = a; bus_b.write_data = d;
    end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? bus_b.ready : bus_a.ready;
  endfunction
  function automatic logic bsy(input bit sel);
    return sel ? bus_b.busy : bus_a.busy;
  endfunction
  function automatic logic erv(input bit sel);
    return sel ? bus_b.err : bus_a.err;
  endfunction
  function automatic logic [31:0] rdv(input bit sel);
    return sel ? bus_b.read_data : bus_a.read_data;
  endfunction

  // One access: called 1 time unit after a rising edge with the DUT idle.
  task automatic run_acc(input bit sel, input logic w, input logic [1:0] s, input logic sx,
                         input logic [7:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output logic er, output int lat,
                         output logic pulse_ok);
    int n;
    n = 0; lat = -1; rd = 32'h0; er = 1'b0; pulse_ok = 1'b0;
    drive(sel, 1'b1, w, s, sx, a, d);
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, SZ_BYTE, 1'b0, 8'h00, 32'h0);
    while (n < 20 && lat < 0) begin
      @(posedge clk); #1;
      n++;
      if (rdy(sel)) begin
        lat = n; rd = rdv(sel); er = erv(sel);
      end
    end
    if (lat > 0) begin
      @(posedge clk); #1;
      pulse_ok = !rdy(sel) && !bsy(sel) && !erv(sel);
    end
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  logic        pok;
  int          pulses, busy_cnt;

  initial begin
    vecs[0]  = '{1'b1, SZ_WORD, 1'b0, 8'h10, 32'h8001FF7E, 32'h00000000, 1'b0, 1};
    vecs[1]  = '{1'b0, SZ_WORD, 1'b0, 8'h10, 32'h0,        32'h8001FF7E, 1'b0, 2};
    vecs[2]  = '{1'b0, SZ_BYTE, 1'b1, 8'h10, 32'h0,        32'hFFFFFF80, 1'b0, 2};
    vecs[3]  = '{1'b0, SZ_BYTE, 1'b0, 8'h11, 32'h0,        32'h00000001, 1'b0, 2};
    vecs[4]  = '{1'b0, SZ_HALF, 1'b1, 8'h12, 32'h0,        32'hFFFFFF7E, 1'b0, 2};
    vecs[5]  = '{1'b0, SZ_HALF, 1'b0, 8'h12, 32'h0,        32'h0000FF7E, 1'b0, 2};
    vecs[6]  = '{1'b1, SZ_HALF, 1'b0, 8'h12, 32'h1234ABCD, 32'h0000FF7E, 1'b0, 1};
    vecs[7]  = '{1'b0, SZ_WORD, 1'b0, 8'h10, 32'h0,        32'h8001ABCD, 1'b0, 2};
    vecs[8]  = '{1'b1, SZ_WORD, 1'b0, 8'h13, 32'h11111111, 32'h8001ABCD, 1'b1, 1};
    vecs[9]  = '{1'b0, SZ_WORD, 1'b0, 8'h10, 32'h0,        32'h8001ABCD, 1'b0, 2};
    vecs[10] = '{1'b0, SZ_WORD, 1'b0, 8'h7E, 32'h0,        32'h00000000, 1'b1, 2};
    vecs[11] = '{1'b0, SZ_WORD, 1'b0, 8'h10, 32'h0,        32'h8001ABCD, 1'b0, 2};
    vecs[12] = '{1'b0, SZ_RSVD, 1'b0, 8'h10, 32'h0,        32'h00000000, 1'b1, 2};
    vecs[13] = '{1'b1, SZ_RSVD, 1'b0, 8'h20, 32'h0,        32'h00000000, 1'b1, 1};
    vecs[14] = '{1'b0, SZ_HALF, 1'b0, 8'h11, 32'h0,        32'h00000000, 1'b1, 2};
    vecs[15] = '{1'b1, SZ_WORD, 1'b0, 8'h7C, 32'hCAFEF00D, 32'h00000000, 1'b0, 1};
    vecs[16] = '{1'b0, SZ_BYTE, 1'b0, 8'h7F, 32'h0,        32'h0000000D, 1'b0, 2};
    vecs[17] = '{1'b0, SZ_BYTE, 1'b0, 8'h80, 32'h0,        32'h00000000, 1'b1, 2};
    vecs[18] = '{1'b1, SZ_BYTE, 1'b0, 8'h80, 32'h000000AA, 32'h00000000, 1'b1, 1};
    vecs[19] = '{1'b0, SZ_WORD, 1'b0, 8'h7C, 32'h0,        32'hCAFEF00D, 1'b0, 2};
    vecs[20] = '{1'b1, SZ_WORD, 1'b0, 8'h20, 32'hC0FFEE01, 32'hCAFEF00D, 1'b0, 1};
    vecs[21] = '{1'b0, SZ_HALF, 1'b0, 8'h22, 32'h0,        32'h0000EE01, 1'b0, 2};
    vecs[22] = '{1'b0, SZ_BYTE, 1'b1, 8'h20, 32'h0,        32'hFFFFFFC0, 1'b0, 2};
    vecs[23] = '{1'b0, SZ_HALF, 1'b1, 8'h20, 32'h0,        32'hFFFFC0FF, 1'b0, 2};

    drive(1'b0, 1'b0, 1'b0, SZ_BYTE, 1'b0, 8'h00, 32'h0);
    drive(1'b1, 1'b0, 1'b0, SZ_BYTE, 1'b0, 8'h00, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {31'b0, bus_a.ready}, 32'h0);
    chk("reset_busy",  {31'b0, bus_a.busy},  32'h0);
    chk("reset_err",   {31'b0, bus_a.err},   32'h0);
    chk("reset_rdata", bus_a.read_data,      32'h0);
    chk("reset_b_busy", {31'b0, bus_b.busy}, 32'h0);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 24; i++) begin
      run_acc(1'b0, vecs[i].we, vecs[i].sz, vecs[i].sx, vecs[i].addr, vecs[i].wd, rd, er, lat, pok);
      chk($sformatf("v%0d_lat", i),   lat,          vecs[i].exp_lat);
      chk($sformatf("v%0d_err", i),   {31'b0, er},  {31'b0, vecs[i].exp_err});
      chk($sformatf("v%0d_rdata", i), rd,           vecs[i].exp_rd);
      chk($sformatf("v%0d_pulse", i), {31'b0, pok}, 32'h1);
    end

    // req while busy is ignored: one response, no second (store) access.
    drive(1'b0, 1'b1, 1'b0, SZ_WORD, 1'b0, 8'h10, 32'h0);
    @(posedge clk); #1;
    pulses = 0; busy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus_a.busy) drive(1'b0, 1'b1, 1'b1, SZ_WORD, 1'b0, 8'h10, 32'h0);
      else            drive(1'b0, 1'b0, 1'b0, SZ_BYTE, 1'b0, 8'h00, 32'h0);
      @(posedge clk); #1;
      if (bus_a.ready) pulses++;
      if (bus_a.busy)  busy_cnt++;
    end
    drive(1'b0, 1'b0, 1'b0, SZ_BYTE, 1'b0, 8'h00, 32'h0);
    chk("busy_req_pulses", pulses, 1);
    chk("busy_req_busycycles", busy_cnt, 2);
    chk("busy_req_rdata", bus_a.read_data, 32'h8001ABCD);
    run_acc(1'b0, 1'b0, SZ_WORD, 1'b0, 8'h10, 32'h0, rd, er, lat, pok);
    chk("busy_req_mem", rd, 32'h8001ABCD);

    // Reset during a WRITE_LAT=3 store aborts it.
    run_acc(1'b1, 1'b1, SZ_WORD, 1'b0, 8'h20, 32'h01020304, rd, er, lat, pok);
    chk("b_store_lat", lat, 3);
    chk("b_store_err", {31'b0, er}, 32'h0);
    drive(1'b1, 1'b1, 1'b1, SZ_WORD, 1'b0, 8'h20, 32'hDEADBEEF);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, SZ_BYTE, 1'b0, 8'h00, 32'h0);
    chk("b_abort_busy_before", {31'b0, bus_b.busy}, 32'h1);
    @(posedge clk); #1;
    rst_b_n = 1'b0;
    #1;
    chk("b_abort_busy", {31'b0, bus_b.busy}, 32'h0);
    chk("b_abort_ready", {31'b0, bus_b.ready}, 32'h0);
    repeat (4) @(posedge clk);
    #1;
    rst_b_n = 1'b1;
    @(posedge clk); #1;
    run_acc(1'b1, 1'b0, SZ_WORD, 1'b0, 8'h20, 32'h0, rd, er, lat, pok);
    chk("b_after_abort_rdata", rd, 32'h01020304);
    chk("b_after_abort_lat", lat, 2);
    chk("b_after_abort_err", {31'b0, er}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
